clock_period_meter: RTL and testbench

//   Receive end of the divided-clock path: samples a slow, asynchronous divided clock
//   (e.g. a divide-by-20 output) in the fast system clock domain, measures its period and

---
 rtl/clock_period_meter.sv | 162 ++++++++++++++++
 tb/tb_clock_period_meter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous divided clock in clk cycles.
// Declares lock after LOCK_N consecutive in-tolerance periods. Define
// CLOCK_METER_GLITCH_FILTER_EN to add a FILT_N-sample glitch filter after the synchronizer.
module clock_period_meter #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned EXP_PERIOD = 20,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned TIMEOUT    = 1024
`ifdef CLOCK_METER_GLITCH_FILTER_EN
    ,
    parameter int unsigned FILT_N     = 3
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned MCNT_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] PER_LO = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_HI = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    logic              sync1_q, sync2_q, s_d_q, s;
    logic              rise, fall, match, tmo;
    logic [CNT_W-1:0]  cnt_q, cnt_d, hcnt_q, hcnt_d, cand;
    logic [CNT_W-1:0]  period_q, period_d, high_time_q, high_time_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d, mcnt_inc;
    logic              valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
    state_t            state_q, state_d;

`ifdef CLOCK_METER_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILT_N + 1);
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // The level only follows s_sync once it has disagreed for FILT_N straight samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_N - 1)) filt_d = sync2_q;
            else                           fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rise     = s & ~s_d_q;
        fall     = ~s & s_d_q;
        cand     = cnt_q + 1'b1;
        match    = (cand >= PER_LO) && (cand <= PER_HI);
        mcnt_inc = mcnt_q + 1'b1;
        cnt_d    = rise ? '0 : ((cnt_q < TMO) ? cnt_q + 1'b1 : cnt_q);
        hcnt_d   = rise ? '0 : ((s && hcnt_q != '1) ? hcnt_q + 1'b1 : hcnt_q);
        // Timeout fires on the edge where cnt reaches TIMEOUT; a coincident rise wins.
        tmo      = (state_q != SEARCH) && !rise && (cnt_d == TMO);

        state_d = state_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            SEARCH: if (rise) begin
                state_d = TRACK;
                mcnt_d  = '0;
            end
            TRACK: if (rise) begin
                if (!match) begin
                    mcnt_d = '0;
                end else if (mcnt_inc == MCNT_W'(LOCK_N)) begin
                    state_d = LOCKED;
                    mcnt_d  = '0;
                end else begin
                    mcnt_d = mcnt_inc;
                end
            end else if (tmo) begin
                state_d = SEARCH;
                mcnt_d  = '0;
            end
            LOCKED: if (rise) begin
                if (!match) begin
                    state_d = TRACK;
                    mcnt_d  = '0;
                end
            end else if (tmo) begin
                state_d = SEARCH;
                mcnt_d  = '0;
            end
            default: begin
                state_d = SEARCH;
                mcnt_d  = '0;
            end
        endcase

        // The first rise out of SEARCH only starts the counter.
        valid_d     = rise && (state_q != SEARCH);
        period_d    = valid_d ? cand : period_q;
        high_time_d = fall ? hcnt_q + 1'b1 : high_time_q;
        locked_d    = (state_d == LOCKED);
        timeout_d   = tmo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            s_d_q       <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            mcnt_q      <= '0;
            state_q     <= SEARCH;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
            sync1_q     <= sig_in;
            sync2_q     <= sync1_q;
            s_d_q       <= s;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            mcnt_q      <= mcnt_d;
            state_q     <= state_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter (default parameters).
// Expectations follow CLOCK_METER_GLITCH_FILTER_EN when that macro is defined for the build.
module tb_clock_period_meter;

    localparam int TIMEOUT = 1024;
`ifdef CLOCK_METER_GLITCH_FILTER_EN
    localparam int LAT  = 6;   // drive-to-registered-output negedges: 2 sync + 3 filter + 1
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [31:0] period, high_time;
    logic        period_valid, locked, timeout;

    int n_pass = 0, n_total = 0;
    int cyc = 0, n_valid = 0, n_tmo = 0, valid_cyc = 0, tmo_cyc = 0;

    clock_period_meter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Event log sampled 1 ns after each active edge; tasks read it at negedges.
    always @(posedge clk) begin
        #1;
        cyc <= cyc + 1;
        if (period_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (timeout) begin
            n_tmo   <= n_tmo + 1;
            tmo_cyc <= cyc;
        end
    end

    task automatic gen_cycle(input int hi, input int lo);
        sig_in = 1'b1;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_reset();
        sig_in  = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic lock_up();
        do_reset();
        repeat (5) gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b1) $display("FAIL lock_up: locked=%0b want 1", locked);
        else n_pass++;
    endtask

    task automatic test_reset();
        sig_in  = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({period_valid, locked, timeout} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {period_valid, locked, timeout});
        else n_pass++;
        n_total++;
        if (period !== 32'd0 || high_time !== 32'd0)
            $display("FAIL reset_counts: period=%0d high_time=%0d want 0/0", period, high_time);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lock();
        int v0;
        do_reset();
        v0 = n_valid;
        gen_cycle(10, 10);
        n_total++;
        if (n_valid - v0 !== 0) $display("FAIL first_rise_no_valid: valids=%0d want 0", n_valid - v0);
        else n_pass++;
        n_total++;
        if (high_time !== 32'd10) $display("FAIL high_time_first: got %0d want 10", high_time);
        else n_pass++;
        gen_cycle(10, 10);
        n_total++;
        if (period !== 32'd20 || n_valid - v0 !== 1)
            $display("FAIL second_rise: period=%0d valids=%0d want 20/1", period, n_valid - v0);
        else n_pass++;
        gen_cycle(10, 10);
        gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b0) $display("FAIL lock_after_4_rises: locked=%0b want 0", locked);
        else n_pass++;
        gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b1 || n_valid - v0 !== 4)
            $display("FAIL lock_after_5_rises: locked=%0b valids=%0d want 1/4", locked, n_valid - v0);
        else n_pass++;
        n_total++;
        if (period !== 32'd20 || high_time !== 32'd10)
            $display("FAIL locked_values: period=%0d high_time=%0d want 20/10", period, high_time);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int t0, v0;
        t0 = n_tmo;
        sig_in = 1'b0;
        repeat (1100) @(negedge clk);
        n_total++;
        if (n_tmo - t0 !== 1) $display("FAIL timeout_count: got %0d pulses want 1", n_tmo - t0);
        else n_pass++;
        n_total++;
        if (tmo_cyc - valid_cyc !== TIMEOUT)
            $display("FAIL timeout_delay: got %0d cycles after last rise want %0d", tmo_cyc - valid_cyc, TIMEOUT);
        else n_pass++;
        n_total++;
        if (locked !== 1'b0 || period !== 32'd20 || high_time !== 32'd10)
            $display("FAIL timeout_hold: locked=%0b period=%0d high_time=%0d want 0/20/10",
                     locked, period, high_time);
        else n_pass++;
        v0 = n_valid;
        gen_cycle(10, 10);
        n_total++;
        if (n_valid - v0 !== 0) $display("FAIL restart_first_rise: valids=%0d want 0", n_valid - v0);
        else n_pass++;
        repeat (4) gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b1) $display("FAIL relock_after_timeout: locked=%0b want 1", locked);
        else n_pass++;
    endtask

    task automatic test_period(input int hi, input int lo, input bit exp_lock, input string tag);
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            gen_cycle(hi, lo);
            n_total++;
            if (locked !== ((exp_lock && k >= 5) ? 1'b1 : 1'b0))
                $display("FAIL %s_locked_rise%0d: got %0b want %0b", tag, k, locked, exp_lock && k >= 5);
            else n_pass++;
            if (k >= 2) begin
                n_total++;
                if (period !== 32'(hi + lo))
                    $display("FAIL %s_period_rise%0d: got %0d want %0d", tag, k, period, hi + lo);
                else n_pass++;
            end
        end
        n_total++;
        if (high_time !== 32'(hi)) $display("FAIL %s_high_time: got %0d want %0d", tag, high_time, hi);
        else n_pass++;
    endtask

    task automatic test_unlock_30();
        lock_up();
        gen_cycle(15, 15);
        sig_in = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        n_total++;
        if (locked !== 1'b1) $display("FAIL slow_rise_pre: locked=%0b want 1", locked);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (period_valid !== 1'b1 || period !== 32'd30 || locked !== 1'b0)
            $display("FAIL slow_rise_unlock: valid=%0b period=%0d locked=%0b want 1/30/0",
                     period_valid, period, locked);
        else n_pass++;
        repeat (10 - LAT) @(negedge clk);
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        repeat (3) gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b0) $display("FAIL relock_early: locked=%0b want 0", locked);
        else n_pass++;
        gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b1) $display("FAIL relock_after_4: locked=%0b want 1", locked);
        else n_pass++;
    endtask

    task automatic test_reset_mid_lock();
        int v0;
        lock_up();
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (locked !== 1'b0 || period !== 32'd0 || high_time !== 32'd0)
            $display("FAIL async_reset: locked=%0b period=%0d high_time=%0d want 0/0/0",
                     locked, period, high_time);
        else n_pass++;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        v0 = n_valid;
        gen_cycle(10, 10);
        gen_cycle(10, 10);
        n_total++;
        if (n_valid - v0 !== 1 || locked !== 1'b0 || period !== 32'd20)
            $display("FAIL restart_search: valids=%0d locked=%0b period=%0d want 1/0/20",
                     n_valid - v0, locked, period);
        else n_pass++;
    endtask

    task automatic test_glitch();
        lock_up();
        sig_in = 1'b1;
        repeat (10) @(negedge clk);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        sig_in = 1'b1;
        @(negedge clk);
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (locked !== (FILT ? 1'b1 : 1'b0))
            $display("FAIL glitch_locked: got %0b want %0b", locked, FILT);
        else n_pass++;
        n_total++;
        if (period !== (FILT ? 32'd20 : 32'd14) || high_time !== (FILT ? 32'd10 : 32'd1))
            $display("FAIL glitch_measure: period=%0d high_time=%0d want %0d/%0d",
                     period, high_time, FILT ? 20 : 14, FILT ? 10 : 1);
        else n_pass++;
        gen_cycle(10, 10);
        n_total++;
        if (period !== (FILT ? 32'd20 : 32'd6) || locked !== FILT)
            $display("FAIL post_glitch_rise: period=%0d locked=%0b want %0d/%0b",
                     period, locked, FILT ? 20 : 6, FILT);
        else n_pass++;
        repeat (4) gen_cycle(10, 10);
        n_total++;
        if (locked !== 1'b1) $display("FAIL glitch_recover: locked=%0b want 1", locked);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_timeout();
        test_period(13, 12, 1'b0, "p25");
        test_period(11, 10, 1'b1, "p21");
        test_period(10, 9, 1'b1, "p19");
        test_period(11, 11, 1'b0, "p22");
        test_unlock_30();
        test_reset_mid_lock();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
